// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-stage access unit (master) and the
// data memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns EX/MEM load/store requests into data-memory
// bus transactions, stalls the upstream pipeline while a transaction is in
// flight, formats store lanes / byte enables and extracts load data.
module mem_access_unit (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_mem,
  input  logic              MemWrite_mem,
  input  logic              MemToReg_mem,
  input  logic              RegWrite_mem,
  input  logic [4:0]        RegWriteAddr_mem,
  input  logic [31:0]       ALUResult_mem,
  input  logic [31:0]       MemWriteData_mem,
  input  logic [1:0]        MemSize_mem,
  input  logic              MemUnsigned_mem,
  mem_access_unit_if.master dmem,
  output logic              MemToReg_out,
  output logic              RegWrite_out,
  output logic [4:0]        RegWriteAddr_out,
  output logic [31:0]       ALUResult_out,
  output logic [31:0]       MemDout_mem,
  output logic              Stall_mem,
  output logic              MisalignErr
);
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10, DONE = 2'b11} state_t;

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mtr_q, mtr_d;
  logic        rw_q, rw_d;
  logic [4:0]  rwa_q, rwa_d;
  logic [31:0] dout_q, dout_d;
  logic        req_s;
  logic        misalign_s;

  // Size 11 is reserved and behaves as a word everywhere (default branches).
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    case (size)
      SZ_HALF: m = a[0];
      SZ_BYTE: m = 1'b0;
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: be = 4'b0001 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_HALF: w = {2{d[15:0]}};
      SZ_BYTE: w = {4{d[7:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                               input logic [1:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (size)
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      default: r = d;
    endcase
    return r;
  endfunction

  // State register and latched transaction fields; reset abandons any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      addr_q  <= 32'h0000_0000;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0000_0000;
      mtr_q   <= 1'b0;
      rw_q    <= 1'b0;
      rwa_q   <= 5'd0;
      dout_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      mtr_q   <= mtr_d;
      rw_q    <= rw_d;
      rwa_q   <= rwa_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state logic, field latching, load capture and MEM/WB-side outputs.
  always_comb begin
    state_d          = state_q;
    store_d          = store_q;
    addr_d           = addr_q;
    size_d           = size_q;
    uns_d            = uns_q;
    wdata_d          = wdata_q;
    mtr_d            = mtr_q;
    rw_d             = rw_q;
    rwa_d            = rwa_q;
    dout_d           = dout_q;
    req_s            = 1'b0;
    misalign_s       = 1'b0;
    Stall_mem        = 1'b0;
    MemToReg_out     = mtr_q;
    RegWrite_out     = 1'b0;
    RegWriteAddr_out = rwa_q;
    ALUResult_out    = addr_q;
    case (state_q)
      IDLE: begin
        MemToReg_out     = MemToReg_mem;
        RegWrite_out     = RegWrite_mem;
        RegWriteAddr_out = RegWriteAddr_mem;
        ALUResult_out    = ALUResult_mem;
        if (MemRead_mem || MemWrite_mem) begin
          RegWrite_out = 1'b0;
          if (is_misaligned(MemSize_mem, ALUResult_mem[1:0])) begin
            misalign_s = 1'b1;
          end else begin
            Stall_mem = 1'b1;
            state_d   = REQ;
            store_d   = MemWrite_mem;
            addr_d    = ALUResult_mem;
            size_d    = MemSize_mem;
            uns_d     = MemUnsigned_mem;
            wdata_d   = MemWriteData_mem;
            mtr_d     = MemToReg_mem;
            rw_d      = RegWrite_mem;
            rwa_d     = RegWriteAddr_mem;
          end
        end else begin
          Stall_mem = 1'b0;
        end
      end
      REQ: begin
        req_s     = 1'b1;
        Stall_mem = 1'b1;
        if (dmem.dmem_ready) begin
          if (store_q) begin
            state_d = DONE;
          end else if (dmem.dmem_rvalid) begin
            dout_d  = load_extract(size_q, uns_q, addr_q[1:0], dmem.dmem_rdata);
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        Stall_mem = 1'b1;
        if (dmem.dmem_rvalid) begin
          dout_d  = load_extract(size_q, uns_q, addr_q[1:0], dmem.dmem_rdata);
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        RegWrite_out = rw_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign MemDout_mem     = dout_q;
  assign MisalignErr     = misalign_s & reset;
  assign dmem.dmem_req   = req_s;
  assign dmem.dmem_we    = store_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_be    = byte_enable(size_q, addr_q[1:0]);
  assign dmem.dmem_wdata = store_lanes(size_q, wdata_q);
endmodule
